bike_bgf_iter_ctrl: RTL
=======================

// Module: bike_bgf_iter_ctrl
// PURPOSE
//  Iteration sequencer for the Black-Gray-Flip (BGF) decoder. It orders the decoder phases:
//  threshold, flip, black-mask and gray-mask on the first iteration, then threshold and flip only.
//  It drives the enable and clear of the downstream saturating iteration counter and reads its
//  count back. It stops on a zero syndrome or after NBITER iterations.
// PARAMETERS
//  NBITER    5  max decoder iterations (>=1); also MAX_VALUE of the attached counter
//  CNT_SIZE  3  width of iteration count; 2**CNT_SIZE > NBITER
// PORTS
//  clk            in   1         system clock, rising edge
//  reset          in   1         asynchronous, active-high reset
//  start          in   1         begin decoding; sampled only in IDLE
//  abort          in   1         synchronous abort; return to IDLE, no done pulse
//  step_done      in   1         one-cycle pulse from datapath: current phase finished
//  syndrome_zero  in   1         syndrome weight == 0; valid when step_done pulses
//  iter_cnt       in   CNT_SIZE  count from the iteration counter (cnt_out)
//  iter_cnt_en    out  1         increment the iteration counter (one-cycle pulse)
//  iter_cnt_rstn  out  1         synchronous active-low clear to the iteration counter
//  phase          out  2         00 THRESH, 01 FLIP, 10 BLACK, 11 GRAY; held during the phase
//  step_start     out  1         one-cycle pulse on the first cycle of every phase
//  busy           out  1         high in every state except IDLE
//  done           out  1         one-cycle pulse when decoding ends
//  success        out  1         result of the last run; valid from done, held until next start
// BEHAVIOUR
//  States: IDLE, CLR, THRESH, FLIP, BLACK, GRAY, CHECK, FIN. All outputs are registered.
//  Reset values: phase=00, all other outputs 0, except iter_cnt_rstn=1. State=IDLE.
//  IDLE: start=1 -> CLR. In CLR, iter_cnt_rstn=0 for exactly one cycle.
//  CLR -> THRESH (next cycle). THRESH: step_start pulses on entry; wait for step_done.
//  THRESH --step_done--> FLIP.
//  FLIP --step_done-->:
//   - BLACK if iter_cnt==0 (first iteration);
//   - CHECK otherwise.
//  BLACK --step_done--> GRAY. GRAY --step_done--> CHECK.
//   - BLACK and GRAY leave the count unchanged.
//  CHECK lasts one cycle. It uses syndrome_zero latched at the last step_done.
//   - zero syndrome -> FIN with success=1.
//   - else if iter_cnt==NBITER-1 -> FIN with success=0.
//   - else -> THRESH.
//   - iter_cnt_en pulses in CHECK in every case; the counter updates one cycle later.
//  The comparison uses the pre-increment count.
//  FIN: done=1 for one cycle, busy=0 next cycle, -> IDLE. The counter then holds
//   the number of completed iterations, saturating at NBITER.
//  The iteration counter may read a value >= NBITER (saturated). Treat this as
//   the last iteration: FIN with success=0.
//  Ignored inputs:
//   - step_done outside THRESH/FLIP/BLACK/GRAY;
//   - step_done on the same cycle as step_start (the phase needs >=1 cycle);
//   - start while busy.
//  abort=1 in any non-IDLE state -> IDLE next cycle: no done, success unchanged,
//   iter_cnt_en=0. abort has priority over step_done and CHECK decisions.
//  Reset mid-operation forces IDLE and the reset values immediately (asynchronous).
//  A start on the same cycle as FIN->IDLE is not accepted; it must be
//   applied in IDLE.
// TESTING
//  Syndrome is zero after the first FLIP:
//   -> phases 00,01,10,11; one en pulse; done with success=1; final count=1.
//  Syndrome never zero, NBITER=5:
//   -> phase sequence 00,01,10,11, then (00,01)x4; five en pulses;
//   -> done with success=0; count=5.
//  Zero at iteration 3:
//   -> done after the third CHECK; success=1; no BLACK/GRAY after iteration 1.
//  abort during GRAY:
//   -> IDLE next cycle; done=0; a new start clears the counter via the iter_cnt_rstn pulse.
//  Spurious inputs:
//   - step_done in IDLE/CHECK, and start while busy -> no state change.
//   - async reset mid-FLIP -> all outputs at reset values before the next clock edge.
//  Force iter_cnt=7 (saturated) in CHECK with a nonzero syndrome -> FIN with success=0.

Source files
------------

// File: rtl/bike_bgf_iter_ctrl.sv
// Iteration sequencer for the BGF decoder: orders threshold/flip/black/gray phases,
// drives the external saturating iteration counter and stops on zero syndrome or NBITER.
module bike_bgf_iter_ctrl #(
  parameter int unsigned NBITER   = 5,
  parameter int unsigned CNT_SIZE = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                step_done,
  input  logic                syndrome_zero,
  input  logic [CNT_SIZE-1:0] iter_cnt,
  output logic                iter_cnt_en,
  output logic                iter_cnt_rstn,
  output logic [1:0]          phase,
  output logic                step_start,
  output logic                busy,
  output logic                done,
  output logic                success
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_THRESH,
    S_FLIP,
    S_BLACK,
    S_GRAY,
    S_CHECK,
    S_FIN
  } state_t;

  localparam logic [CNT_SIZE-1:0] LAST_ITER = CNT_SIZE'(NBITER - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_phase;
  logic        r_step_start;
  logic        r_busy;
  logic        r_done;
  logic        r_en;
  logic        r_rstn;
  logic        r_success;
  logic        r_sz;

  logic        w_in_phase;
  logic        w_accept;
  logic        w_next_is_phase;
  logic        w_step_start_next;
  logic [1:0]  w_phase_next;
  logic        w_sz_next;
  logic        w_succ_next;

  // A step_done coinciding with step_start is ignored: each phase lasts at least one cycle.
  always_comb begin
    w_in_phase = (r_state == S_THRESH) || (r_state == S_FLIP) ||
                 (r_state == S_BLACK)  || (r_state == S_GRAY);
    w_accept   = w_in_phase && step_done && !r_step_start;
  end

  always_comb begin
    w_next      = r_state;
    w_succ_next = r_success;
    w_sz_next   = r_sz;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next      = S_CLR;
          w_succ_next = 1'b0;
        end
      end
      S_CLR:    w_next = S_THRESH;
      S_THRESH: if (w_accept) w_next = S_FLIP;
      S_FLIP: begin
        if (w_accept) w_next = (iter_cnt == '0) ? S_BLACK : S_CHECK;
      end
      S_BLACK:  if (w_accept) w_next = S_GRAY;
      S_GRAY:   if (w_accept) w_next = S_CHECK;
      S_CHECK: begin
        // iter_cnt is still the pre-increment value here; saturated counts end the run too.
        if (r_sz) begin
          w_next      = S_FIN;
          w_succ_next = 1'b1;
        end else if (iter_cnt >= LAST_ITER) begin
          w_next      = S_FIN;
          w_succ_next = 1'b0;
        end else begin
          w_next = S_THRESH;
        end
      end
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase

    if (w_accept) w_sz_next = syndrome_zero;

    if (abort && (r_state != S_IDLE)) begin
      w_next      = S_IDLE;
      w_succ_next = r_success;
      w_sz_next   = r_sz;
    end
  end

  always_comb begin
    w_phase_next    = r_phase;
    w_next_is_phase = 1'b1;
    unique case (w_next)
      S_THRESH: w_phase_next = 2'b00;
      S_FLIP:   w_phase_next = 2'b01;
      S_BLACK:  w_phase_next = 2'b10;
      S_GRAY:   w_phase_next = 2'b11;
      default:  w_next_is_phase = 1'b0;
    endcase
    w_step_start_next = w_next_is_phase && (w_next != r_state);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_step_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_en         <= 1'b0;
      r_rstn       <= 1'b1;
      r_success    <= 1'b0;
      r_sz         <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_phase      <= w_phase_next;
      r_step_start <= w_step_start_next;
      r_busy       <= (w_next != S_IDLE);
      r_done       <= (w_next == S_FIN);
      r_en         <= (w_next == S_CHECK);
      r_rstn       <= (w_next != S_CLR);
      r_success    <= w_succ_next;
      r_sz         <= w_sz_next;
    end
  end

  assign iter_cnt_en   = r_en;
  assign iter_cnt_rstn = r_rstn;
  assign phase         = r_phase;
  assign step_start    = r_step_start;
  assign busy          = r_busy;
  assign done          = r_done;
  assign success       = r_success;

endmodule
